// File: rtl/adc_spi_receiver.sv
// rtl/adc_spi_receiver.sv - SPI master capture of a 12-bit serial ADC; optional check enabled by ADC_ZERO_CHECK_EN
module adc_spi_receiver #(
  parameter int SAMPLE_PERIOD = 2268,
  parameter int SCK_DIV       = 4,
  parameter int FRAME_BITS    = 16,
  parameter int DATA_BITS     = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 miso,
  output logic                 cs_n,
  output logic                 sck,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(SCK_DIV);
  localparam int BW = $clog2(FRAME_BITS + 1);
`ifdef ADC_ZERO_CHECK_EN
  // Whole frame is kept so the leading zeros can be inspected.
  localparam int SW = FRAME_BITS;
`else
  // Leading zeros simply shift out of the top of a data-wide register.
  localparam int SW = DATA_BITS;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] shift;
  logic          miso_m;
  logic          miso_s;
  logic          tick;
  logic          div_end;
  logic          frame_end;

  assign tick      = enable && (period_cnt == PW'(SAMPLE_PERIOD - 1));
  assign div_end   = (div_cnt == DW'(SCK_DIV - 1));
  // Last high phase of sck has elapsed after the final rising edge.
  assign frame_end = (state == SHIFT) && div_end && sck && (bit_cnt == BW'(FRAME_BITS));

  // Two-flop synchronizer for the asynchronous ADC data line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miso_m <= 1'b0;
      miso_s <= 1'b0;
    end else begin
      miso_m <= miso;
      miso_s <= miso_m;
    end
  end

  // Free-running sample-rate counter, parked at zero while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt <= '0;
    end else if (!enable) begin
      period_cnt <= '0;
    end else if (period_cnt == PW'(SAMPLE_PERIOD - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Frame sequencer: chip select, serial clock, capture and output strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      cs_n       <= 1'b1;
      sck        <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state   <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        SETUP: begin
          if (div_end) begin
            state   <= SHIFT;
            sck     <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (!sck) begin
              sck     <= 1'b1;
              shift   <= {shift[SW-2:0], miso_s};
              bit_cnt <= bit_cnt + 1'b1;
            end else if (frame_end) begin
              state      <= DONE;
              cs_n       <= 1'b1;
              data_out   <= shift[DATA_BITS-1:0];
              data_valid <= 1'b1;
            end else begin
              sck <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          state   <= QUIET;
          div_cnt <= '0;
        end
        QUIET: begin
          if (div_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_ZERO_CHECK_EN
  logic enable_d;
  logic rearm;
  logic enable_rise;

  assign enable_rise = enable && !enable_d;

  // Sticky leading-zero violation; a clean frame after an enable re-assert clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_d  <= 1'b0;
      rearm     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      enable_d <= enable;
      if (frame_end) begin
        if (|shift[FRAME_BITS-1:DATA_BITS]) begin
          frame_err <= 1'b1;
          rearm     <= 1'b0;
        end else if (rearm || enable_rise) begin
          frame_err <= 1'b0;
          rearm     <= 1'b0;
        end
      end else if (enable_rise) begin
        rearm <= 1'b1;
      end
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_receiver.sv
// tb/tb_adc_spi_receiver.sv - randomized self-checking bench for adc_spi_receiver
`timescale 1ns/1ps
module tb_adc_spi_receiver;

  localparam int SP       = 200;
  localparam int SD       = 4;
  localparam int FB       = 16;
  localparam int DB       = 12;
  localparam int CS_LOW   = SD * (1 + 2 * FB);
  localparam int BUSY_LEN = CS_LOW + 1 + SD;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          enable = 1'b0;
  logic          miso   = 1'b0;
  logic          cs_n;
  logic          sck;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          frame_err;

  adc_spi_receiver #(
    .SAMPLE_PERIOD(SP),
    .SCK_DIV(SD),
    .FRAME_BITS(FB),
    .DATA_BITS(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .miso(miso),
    .cs_n(cs_n),
    .sck(sck),
    .data_out(data_out),
    .data_valid(data_valid),
    .busy(busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // ADC slave: word latched at cs_n fall, next bit presented after each sck fall with async skew.
  logic [FB-1:0] adc_word  = '0;
  logic [FB-1:0] adc_frame = '0;
  int            adc_k     = 0;
  always @(negedge cs_n or negedge sck) begin
    logic        b;
    int unsigned skew;
    if (cs_n == 1'b0) begin
      if (sck) begin
        adc_frame = adc_word;
        adc_k     = 0;
        b         = adc_word[FB-1];
      end else begin
        b = (adc_k < FB) ? adc_frame[FB-1-adc_k] : 1'b0;
        adc_k++;
      end
      skew = $urandom_range(1, 18);
      #(skew) miso = b;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: frame timing derived from the start cycle t0.
  int            pc      = 0;
  bit            act     = 0;
  int            t0      = 0;
  logic [FB-1:0] m_word  = '0;
  logic [DB-1:0] m_data  = '0;
  bit            m_err   = 0;
  bit            m_arm   = 0;
  bit            en_prev = 0;

  // Observations of the DUT used by the hand-computed checks.
  logic cs_prev      = 1'b1;
  logic sck_prev     = 1'b1;
  int   last_fall    = -1;
  int   last_dv      = -1;
  int   rises        = 0;
  int   low_len      = 0;
  int   last_low_len = 0;
  int   n_falls      = 0;
  int   dv_count     = 0;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act_v, exp_v);
    end
  endtask

  task automatic step();
    int   o;
    bit   was_act;
    bit   tk;
    logic e_cs, e_sck, e_dv, e_busy;
    @(negedge clk);
    if (!rst) begin
      pc = 0; act = 0; m_data = '0; m_err = 0; m_arm = 0; en_prev = 0;
    end
    o      = cyc - t0;
    e_cs   = !(act && o < CS_LOW);
    if (act && o < CS_LOW) e_sck = (o < SD) ? 1'b1 : ((((o - SD) / SD) % 2) == 1);
    else e_sck = 1'b1;
    e_dv   = act && (o == CS_LOW);
    e_busy = act && (o < BUSY_LEN);
    if (e_dv) begin
      m_data = m_word[DB-1:0];
`ifdef ADC_ZERO_CHECK_EN
      if (m_word[FB-1:DB] != 0) begin m_err = 1; m_arm = 0; end
      else if (m_arm) begin m_err = 0; m_arm = 0; end
`endif
    end
    chk("cs_n", cs_n, e_cs);
    chk("sck", sck, e_sck);
    chk("data_valid", data_valid, e_dv);
    chk("busy", busy, e_busy);
    chk("data_out", data_out, m_data);
    chk("frame_err", frame_err, m_err);

    if (!cs_n && cs_prev) begin last_fall = cyc; rises = 0; low_len = 0; n_falls++; end
    if (!cs_n) low_len++;
    if (cs_n && !cs_prev) last_low_len = low_len;
    if (!cs_n && sck && !sck_prev) rises++;
    if (data_valid) begin last_dv = cyc; dv_count++; end
    cs_prev  = cs_n;
    sck_prev = sck;

    if (rst) begin
      was_act = act;
      tk      = enable && (pc == SP - 1);
      if (act && o == BUSY_LEN - 1) act = 0;
      if (!was_act && tk) begin act = 1; t0 = cyc + 1; m_word = adc_word; end
      pc = enable ? ((pc == SP - 1) ? 0 : pc + 1) : 0;
      if (enable && !en_prev) m_arm = 1;
      en_prev = enable;
    end
    cyc++;
    @(posedge clk);
    #2;
  endtask

  task automatic run_until_dv(input string name, input int maxc);
    int start;
    start = dv_count;
    for (int i = 0; i < maxc && dv_count == start; i++) step();
    chk({name, "_dv_seen"}, (dv_count != start), 1);
  endtask

  task automatic run_until_fall(input string name, input int maxc);
    int start;
    start = n_falls;
    for (int i = 0; i < maxc && n_falls == start; i++) step();
    chk({name, "_fall_seen"}, (n_falls != start), 1);
  endtask

  initial begin
    int en_cyc;
    int d1;
    int rel_cyc;
    int falls0;
    int dvs0;

    // Reset state
    repeat (3) step();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sck", sck, 1);
    chk("rst_data", data_out, 0);

    // Single frame 0x0ABC
    rst      = 1'b1;
    enable   = 1'b1;
    adc_word = 16'h0ABC;
    en_cyc   = cyc;
    run_until_dv("t1", 400);
    chk("t1_fall_cycle", last_fall - en_cyc, 200);
    chk("t1_latency", last_dv - last_fall, 132);
    chk("t1_data", data_out, 12'hABC);
    chk("t1_rises", rises, 16);
    chk("t1_cs_low", last_low_len, 132);

    // Back-to-back frames
    adc_word = 16'h0FFF;
    run_until_dv("t2a", 400);
    chk("t2a_data", data_out, 12'hFFF);
    d1       = last_dv;
    adc_word = 16'h0001;
    run_until_dv("t2b", 400);
    chk("t2b_data", data_out, 12'h001);
    chk("t2_spacing", last_dv - d1, 200);

    // Reset mid-frame at the 8th rising sck edge
    adc_word = 16'h0555;
    run_until_fall("t3", 400);
    for (int i = 0; i < 200 && rises < 8; i++) step();
    chk("t3_rises_reached", rises, 8);
    dvs0 = dv_count;
    rst  = 1'b0;
    #1;
    chk("t3_cs_n_now", cs_n, 1);
    chk("t3_sck_now", sck, 1);
    chk("t3_busy_now", busy, 0);
    repeat (2) step();
    rst      = 1'b1;
    adc_word = 16'h0123;
    rel_cyc  = cyc;
    run_until_dv("t3", 500);
    chk("t3_no_partial_dv", dv_count - dvs0, 1);
    chk("t3_data", data_out, 12'h123);
    chk("t3_restart_fall", last_fall - rel_cyc, 200);

    // enable dropped 10 cycles into a frame
    adc_word = 16'h0777;
    run_until_fall("t4", 400);
    repeat (10) step();
    enable = 1'b0;
    run_until_dv("t4", 300);
    chk("t4_data", data_out, 12'h777);
    falls0 = n_falls;
    repeat (1000) step();
    chk("t4_no_falls", n_falls - falls0, 0);
    chk("t4_data_held", data_out, 12'h777);

    // Leading-zero violation followed by a clean frame
    enable   = 1'b1;
    adc_word = 16'h8ABC;
    run_until_dv("t5a", 400);
    chk("t5a_data", data_out, 12'hABC);
`ifdef ADC_ZERO_CHECK_EN
    chk("t5a_err", frame_err, 1);
`else
    chk("t5a_err", frame_err, 0);
`endif
    adc_word = 16'h0ABC;
    run_until_dv("t5b", 400);
    chk("t5b_data", data_out, 12'hABC);
`ifdef ADC_ZERO_CHECK_EN
    chk("t5b_err_held", frame_err, 1);
`else
    chk("t5b_err_held", frame_err, 0);
`endif

    // Randomized frames with random words and enable gaps
    for (int n = 0; n < 15; n++) begin
      adc_word = 16'($urandom);
      enable   = 1'b1;
      run_until_dv("rnd", 450);
      chk("rnd_data", data_out, {20'h0, adc_word[DB-1:0]});
      if ($urandom_range(0, 2) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 300)) step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
